// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter and hazard scoreboard for the 32 x 32-bit register file.
// Two writeback requesters (0 = ALU, 1 = load unit) share the file's single
// write port under round-robin arbitration. The selected write is registered
// onto the port one cycle after acceptance. A busy vector tracks in-flight
// destinations so the issue stage can stall on RAW and WAW hazards.
module regfile_wb_arbiter #(
  parameter int XLEN = 32,
  parameter int AW   = 5
) (
  input  logic            clk,
  input  logic            rst,

  input  logic            wb_valid0,
  input  logic [AW-1:0]   wb_rd0,
  input  logic [XLEN-1:0] wb_data0,
  output logic            wb_ready0,

  input  logic            wb_valid1,
  input  logic [AW-1:0]   wb_rd1,
  input  logic [XLEN-1:0] wb_data1,
  output logic            wb_ready1,

  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   issue_rs1,
  input  logic [AW-1:0]   issue_rs2,
  output logic            issue_ready,

  output logic [(1<<AW)-1:0] busy,

  output logic            write_enable,
  output logic [AW-1:0]   RD,
  output logic [XLEN-1:0] Write_data
);

  localparam int NREG = 1 << AW;

  // Requester that won the most recent contest; 1 after reset so the ALU
  // wins the first contest.
  logic last_grant;
  logic grant0;
  logic grant1;

  logic hz_rs1;
  logic hz_rs2;
  logic hz_rd;
  logic issue_fire;

  logic [NREG-1:0] busy_next;

  // Round-robin grant: a lone requester always wins; on a tie the requester
  // that did not win last time is granted.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (wb_valid0 && wb_valid1) begin
      grant0 = last_grant;
      grant1 = ~last_grant;
    end else begin
      grant0 = wb_valid0;
      grant1 = wb_valid1;
    end
  end

  assign wb_ready0 = grant0;
  assign wb_ready1 = grant1;

  // Remember the winner; with no request the previous winner is kept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant <= 1'b1;
    end else if (grant0) begin
      last_grant <= 1'b0;
    end else if (grant1) begin
      last_grant <= 1'b1;
    end
  end

  // Output stage: capture the accepted write. A write to x0 still consumes
  // the grant and updates RD/Write_data, but never enables the file write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      write_enable <= 1'b0;
      RD           <= '0;
      Write_data   <= '0;
    end else if (grant0) begin
      write_enable <= (wb_rd0 != '0);
      RD           <= wb_rd0;
      Write_data   <= wb_data0;
    end else if (grant1) begin
      write_enable <= (wb_rd1 != '0);
      RD           <= wb_rd1;
      Write_data   <= wb_data1;
    end else begin
      write_enable <= 1'b0;
    end
  end

  // Hazard check against the current busy vector; x0 never stalls.
  always_comb begin
    hz_rs1      = (issue_rs1 != '0) && busy[issue_rs1];
    hz_rs2      = (issue_rs2 != '0) && busy[issue_rs2];
    hz_rd       = (issue_rd  != '0) && busy[issue_rd];
    issue_ready = ~(hz_rs1 | hz_rs2 | hz_rd);
    issue_fire  = issue_valid && issue_ready && (issue_rd != '0);
  end

  // Scoreboard next state: commit clears first so a same-edge issue to the
  // same register leaves it busy.
  always_comb begin
    busy_next = busy;
    if (write_enable) begin
      busy_next[RD] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_rd] = 1'b1;
    end
    busy_next[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= '0;
    end else begin
      busy <= busy_next;
    end
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: directed vector table, hand-written
// scoreboard/reset sequences, and randomized traffic against a reference model.
module tb_regfile_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid0, wb_valid1;
  logic [4:0]  wb_rd0, wb_rd1;
  logic [31:0] wb_data0, wb_data1;
  logic        wb_ready0, wb_ready1;
  logic        issue_valid;
  logic [4:0]  issue_rd, issue_rs1, issue_rs2;
  logic        issue_ready;
  logic [31:0] busy;
  logic        write_enable;
  logic [4:0]  RD;
  logic [31:0] Write_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] regs [32];

  regfile_wb_arbiter #(.XLEN(32), .AW(5)) dut (
    .clk(clk), .rst(rst),
    .wb_valid0(wb_valid0), .wb_rd0(wb_rd0), .wb_data0(wb_data0), .wb_ready0(wb_ready0),
    .wb_valid1(wb_valid1), .wb_rd1(wb_rd1), .wb_data1(wb_data1), .wb_ready1(wb_ready1),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_rs1(issue_rs1),
    .issue_rs2(issue_rs2), .issue_ready(issue_ready),
    .busy(busy),
    .write_enable(write_enable), .RD(RD), .Write_data(Write_data)
  );

  always #5 clk = ~clk;

  // Register file model fed by the write port.
  always @(posedge clk) begin
    if (!rst && write_enable && RD != 5'd0) regs[RD] <= Write_data;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wb_valid0 = 0; wb_rd0 = 0; wb_data0 = 0;
    wb_valid1 = 0; wb_rd1 = 0; wb_data1 = 0;
    issue_valid = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    rst = 0;
    #1;
  endtask

  typedef struct {
    logic        do_rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        e_r0;
    logic        e_r1;
    logic        e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;
  } vec_t;

  vec_t vecs [7];

  // Reference model state for the random phase.
  int          m_last;
  bit          m_busy [32];
  bit          m_we;
  int          m_rd;
  logic [31:0] m_data;

  function automatic logic [31:0] model_busy_vec();
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 32; i++) if (m_busy[i]) v = v + (32'd1 << i);
    return v;
  endfunction

  initial begin
    logic [31:0] x12_before;
    int winner;
    bit exp_ir;
    bit rq_v [2];
    int rq_rd [2];
    logic [31:0] rq_d [2];

    for (int i = 0; i < 32; i++) regs[i] = 32'd0;

    //            rst v0 rd0 d0            v1 rd1 d1            r0 r1 we rd  data
    vecs[0] = '{1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,        1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    vecs[2] = '{1'b0, 1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b1, 1'b1, 5'd4, 32'h22};
    vecs[3] = '{1'b0, 1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b1, 1'b0, 1'b1, 5'd3, 32'h11};
    vecs[4] = '{1'b0, 1'b1, 5'd3, 32'h11,       1'b1, 5'd4, 32'h22,       1'b0, 1'b1, 1'b1, 5'd4, 32'h22};
    vecs[5] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 5'd0, 32'hFFFFFFFF};
    vecs[6] = '{1'b0, 1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 1'b0, 5'd0, 32'hFFFFFFFF};

    rst = 1;
    idle_inputs();
    #2;
    chk("reset_we",   32'(write_enable), 32'd0);
    chk("reset_rd",   32'(RD),           32'd0);
    chk("reset_data", Write_data,        32'd0);
    chk("reset_busy", busy,              32'd0);
    do_reset();

    // Directed arbitration vectors.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].do_rst) do_reset();
      wb_valid0 = vecs[i].v0; wb_rd0 = vecs[i].rd0; wb_data0 = vecs[i].d0;
      wb_valid1 = vecs[i].v1; wb_rd1 = vecs[i].rd1; wb_data1 = vecs[i].d1;
      #1;
      chk($sformatf("vec%0d_ready0", i), 32'(wb_ready0), 32'(vecs[i].e_r0));
      chk($sformatf("vec%0d_ready1", i), 32'(wb_ready1), 32'(vecs[i].e_r1));
      chk($sformatf("vec%0d_one_ready", i), 32'(wb_ready0 & wb_ready1), 32'd0);
      step();
      chk($sformatf("vec%0d_we", i),   32'(write_enable), 32'(vecs[i].e_we));
      chk($sformatf("vec%0d_rd", i),   32'(RD),           32'(vecs[i].e_rd));
      chk($sformatf("vec%0d_data", i), Write_data,        vecs[i].e_data);
      if (i == 0) begin
        idle_inputs();
        step();
        chk("x5_written", regs[5], 32'hDEADBEEF);
      end
    end
    step();
    chk("x0_zero",  regs[0], 32'd0);
    chk("x3_value", regs[3], 32'h11);
    chk("x4_value", regs[4], 32'h22);

    // RAW hazard through the scoreboard.
    do_reset();
    issue_valid = 1; issue_rd = 7;
    #1;
    chk("raw_issue_ready0", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 0; issue_rd = 0;
    chk("raw_busy7_set", 32'(busy[7]), 32'd1);
    issue_valid = 1; issue_rs1 = 7; issue_rd = 8;
    #1;
    chk("raw_stall", 32'(issue_ready), 32'd0);
    wb_valid0 = 1; wb_rd0 = 7; wb_data0 = 32'h77;
    step();
    wb_valid0 = 0;
    chk("raw_busy7_in_flight", 32'(busy[7]), 32'd1);
    chk("raw_still_stalled", 32'(issue_ready), 32'd0);
    step();
    chk("raw_busy7_clear", 32'(busy[7]), 32'd0);
    chk("raw_issue_ok", 32'(issue_ready), 32'd1);
    chk("raw_x7", regs[7], 32'h77);
    issue_valid = 0; issue_rs1 = 0; issue_rd = 0;

    // Same-edge commit and issue to x9: set wins.
    do_reset();
    wb_valid0 = 1; wb_rd0 = 9; wb_data0 = 32'h99;
    step();
    wb_valid0 = 0;
    chk("same_we", 32'(write_enable), 32'd1);
    issue_valid = 1; issue_rd = 9;
    #1;
    chk("same_issue_ready", 32'(issue_ready), 32'd1);
    step();
    issue_valid = 0; issue_rd = 0;
    chk("same_busy9", 32'(busy[9]), 32'd1);
    chk("same_x9", regs[9], 32'h99);

    // Reset while a write to x12 sits in the output stage.
    x12_before = regs[12];
    wb_valid0 = 1; wb_rd0 = 12; wb_data0 = 32'hC0FFEE12;
    step();
    wb_valid0 = 0;
    chk("rst_mid_we_before", 32'(write_enable), 32'd1);
    chk("rst_mid_rd_before", 32'(RD), 32'd12);
    rst = 1;
    #1;
    chk("rst_mid_we", 32'(write_enable), 32'd0);
    chk("rst_mid_busy", busy, 32'd0);
    step();
    rst = 0;
    step();
    chk("rst_mid_x12", regs[12], x12_before);

    // Randomized traffic against the reference model.
    do_reset();
    m_last = 1; m_we = 0; m_rd = 0; m_data = 0;
    for (int i = 0; i < 32; i++) m_busy[i] = 0;
    rq_v[0] = 0; rq_v[1] = 0;
    for (int cyc = 0; cyc < 500; cyc++) begin
      for (int k = 0; k < 2; k++) begin
        if (!rq_v[k] && ($urandom_range(0, 2) != 0)) begin
          rq_v[k] = 1;
          rq_rd[k] = $urandom_range(0, 7);
          rq_d[k] = $urandom;
        end
      end
      wb_valid0 = rq_v[0]; wb_rd0 = 5'(rq_rd[0]); wb_data0 = rq_d[0];
      wb_valid1 = rq_v[1]; wb_rd1 = 5'(rq_rd[1]); wb_data1 = rq_d[1];
      issue_valid = 1'($urandom_range(0, 1));
      issue_rd  = 5'($urandom_range(0, 7));
      issue_rs1 = 5'($urandom_range(0, 7));
      issue_rs2 = 5'($urandom_range(0, 7));
      #1;

      if (rq_v[0] && rq_v[1]) winner = 1 - m_last;
      else if (rq_v[0])       winner = 0;
      else if (rq_v[1])       winner = 1;
      else                    winner = -1;
      exp_ir = !((issue_rs1 != 0 && m_busy[issue_rs1]) ||
                 (issue_rs2 != 0 && m_busy[issue_rs2]) ||
                 (issue_rd  != 0 && m_busy[issue_rd]));
      chk("rnd_ready0", 32'(wb_ready0), 32'(winner == 0));
      chk("rnd_ready1", 32'(wb_ready1), 32'(winner == 1));
      chk("rnd_issue_ready", 32'(issue_ready), 32'(exp_ir));

      if (m_we) m_busy[m_rd] = 0;
      if (issue_valid && exp_ir && issue_rd != 0) m_busy[issue_rd] = 1;
      if (winner >= 0) begin
        m_last = winner;
        m_we   = (rq_rd[winner] != 0);
        m_rd   = rq_rd[winner];
        m_data = rq_d[winner];
        rq_v[winner] = 0;
      end else begin
        m_we = 0;
      end

      step();
      chk("rnd_we",   32'(write_enable), 32'(m_we));
      chk("rnd_rd",   32'(RD),           32'(m_rd));
      chk("rnd_data", Write_data,        m_data);
      chk("rnd_busy", busy,              model_busy_vec());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
